// File: rtl/firing_control.sv
// firing_control: three-shot round sequencer fed by a synchronised, debounced
// fire button; the state register is the datapath control code.
module firing_control #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       trigger,
   input  logic       round_start,
   input  logic       round_abort,
   output logic [2:0] control,
   output logic       shot_fired,
   output logic       ammo_empty
);
   typedef enum logic [2:0] {
      PRELOAD = 3'b010,
      HOLD1   = 3'b000,
      SHOT1   = 3'b001,
      HOLD2   = 3'b101,
      SHOT2   = 3'b100,
      HOLD3   = 3'b110,
      SHOT3   = 3'b111,
      OUT     = 3'b011
   } state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   state_t           state_q, state_d;
   logic             sync1_q, sync2_q, db_q, db_d, db_dly_q, trig_edge;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Counter only runs while the synchronised level disagrees with the accepted one.
   assign cnt_d     = (sync2_q != db_q && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
   assign db_d      = (sync2_q != db_q && cnt_q == LAST) ? sync2_q : db_q;
   assign trig_edge = db_q & ~db_dly_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         cnt_q    <= '0;
         state_q  <= PRELOAD;
      end else begin
         sync1_q  <= trigger;
         sync2_q  <= sync1_q;
         db_q     <= db_d;
         db_dly_q <= db_q;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
      end
   end
   // Abort is checked before the trigger edge so a simultaneous press never fires.
   always_comb begin
      state_d = state_q;
      case (state_q)
         PRELOAD: state_d = round_start ? HOLD1 : PRELOAD;
         HOLD1:   state_d = round_abort ? OUT : (trig_edge ? SHOT1 : HOLD1);
         SHOT1:   state_d = HOLD2;
         HOLD2:   state_d = round_abort ? OUT : (trig_edge ? SHOT2 : HOLD2);
         SHOT2:   state_d = HOLD3;
         HOLD3:   state_d = round_abort ? OUT : (trig_edge ? SHOT3 : HOLD3);
         SHOT3:   state_d = OUT;
         OUT:     state_d = round_start ? PRELOAD : OUT;
      endcase
   end
   assign control    = state_q;
   assign shot_fired = state_q inside {SHOT1, SHOT2, SHOT3};
   assign ammo_empty = state_q == OUT;
endmodule

// File: tb/tb_firing_control.sv
// tb_firing_control: scenario-driven scoreboard bench for firing_control with
// a four-cycle debounce window.
module tb_firing_control;
   localparam logic [2:0] PRE = 3'b010, H1 = 3'b000, S1 = 3'b001, H2 = 3'b101,
                          S2 = 3'b100, H3 = 3'b110, S3 = 3'b111, OUT = 3'b011;
   typedef struct {
      string      tag;
      logic [2:0] ctrl;
   } exp_t;
   logic       clk = 1'b0, reset = 1'b1, trigger = 1'b0, round_start = 1'b0, round_abort = 1'b0;
   logic [2:0] control;
   logic       shot_fired, ammo_empty;
   exp_t       sb[$];
   int         checks = 0, errors = 0;
   firing_control #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .trigger(trigger), .round_start(round_start),
      .round_abort(round_abort), .control(control), .shot_fired(shot_fired),
      .ammo_empty(ammo_empty)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   // Expected value for the edge just taken is queued; the monitor compares it half a cycle later.
   task automatic tick(input string tag, input logic [2:0] exp);
      @(posedge clk);
      sb.push_back('{tag, exp});
      #1;
   endtask
   task automatic ticks(input int n, input string tag, input logic [2:0] exp);
      for (int i = 0; i < n; i++) tick(tag, exp);
   endtask
   // Press held 10 samples then released: six samples of latency before the shot edge.
   task automatic press(input string tag, input logic [2:0] h, input logic [2:0] s, input logic [2:0] n);
      trigger = 1'b1;
      ticks(6, {tag, "_hold"}, h);
      tick({tag, "_shot"}, s);
      ticks(3, {tag, "_after"}, n);
      trigger = 1'b0;
      ticks(8, {tag, "_rel"}, n);
   endtask
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, "_ctrl"}, 32'(control), 32'(e.ctrl));
         check({e.tag, "_shot"}, 32'(shot_fired), 32'(e.ctrl == S1 || e.ctrl == S2 || e.ctrl == S3));
         check({e.tag, "_empty"}, 32'(ammo_empty), 32'(e.ctrl == OUT));
      end
   end
   initial begin
      ticks(2, "reset", PRE);
      reset = 1'b0;
      tick("idle", PRE);
      round_start = 1'b1;
      tick("arm", H1);
      round_start = 1'b0;
      tick("armed", H1);
      press("p1", H1, S1, H2);
      press("p2", H2, S2, H3);
      press("p3", H3, S3, OUT);
      press("p4", OUT, OUT, OUT);
      round_start = 1'b1;
      tick("rearm_pre", PRE);
      tick("rearm_h1", H1);
      tick("rs_ignored", H1);
      round_start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         trigger = (i % 3) != 2;
         tick("bounce", H1);
      end
      trigger = 1'b0;
      ticks(8, "bounce_rel", H1);
      press("p5", H1, S1, H2);
      trigger = 1'b1;
      ticks(6, "race_hold", H2);
      round_abort = 1'b1;
      tick("race_abort", OUT);
      round_abort = 1'b0;
      ticks(2, "race_after", OUT);
      trigger = 1'b0;
      ticks(8, "race_rel", OUT);
      round_start = 1'b1;
      tick("r3_pre", PRE);
      tick("r3_h1", H1);
      round_start = 1'b0;
      press("p6", H1, S1, H2);
      trigger = 1'b1;
      ticks(6, "mid_hold", H2);
      tick("mid_shot", S2);
      reset = 1'b1;
      round_start = 1'b1;
      tick("mid_reset", PRE);
      reset = 1'b0;
      round_start = 1'b0;
      ticks(10, "held_pre", PRE);
      round_start = 1'b1;
      tick("held_arm", H1);
      round_start = 1'b0;
      ticks(10, "held_h1", H1);
      trigger = 1'b0;
      ticks(8, "held_rel", H1);
      press("p7", H1, S1, H2);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      check("drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
